// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide unit.
// State encoding and the terminal step index for 32-step operations.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } md_state_e;

    localparam int MULTDIV_STEPS_32 = 31;

endpackage

// File: rtl/cycle_count_reg.sv
// Step counter register for the multdiv cycle sequencer.
// Synchronous clear wins over increment.
module cycle_count_reg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next count: clear first, then advance by one.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rs) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/multdiv_cycle_counter.sv
// Cycle sequencer pacing multiply/divide iterations.
// Start arms a run to a captured limit; done pulses one cycle at the end.
module multdiv_cycle_counter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             start,
    input  logic             abort,
    input  logic             stall,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);

    md_state_e        state_q;
    md_state_e        state_d;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] limit_d;
    logic [WIDTH-1:0] cnt_w;
    logic             at_lim;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             lim_load;

    assign at_lim = (cnt_w == limit_q);

    // State and captured limit registers.
    always_ff @(posedge clk) begin
        if (rs) begin
            state_q <= IDLE;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
        end
    end

    // Next state: abort beats start, which beats stall/advance.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!stall && at_lim) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!abort && start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter controls, limit capture and register-only output decodes.
    always_comb begin
        lim_load = (state_q != RUN) && start && !abort;
        limit_d  = lim_load ? limit : limit_q;
        cnt_clr  = (state_q != RUN) || abort;
        cnt_inc  = (state_q == RUN) && !abort && !stall && !at_lim;
        busy     = (state_q == RUN);
        last     = (state_q == RUN) && at_lim;
        done     = (state_q == DONE);
    end

    cycle_count_reg #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk(clk),
        .rs (rs),
        .clr(cnt_clr),
        .inc(cnt_inc),
        .q  (cnt_w)
    );

    assign count = cnt_w;

endmodule

// File: tb/tb_multdiv_cycle_counter.sv
// Directed bench for multdiv_cycle_counter, WIDTH=5 and WIDTH=8 instances.
// A behavioural model is compared every cycle; literal checks pin timing.
module tb_multdiv_cycle_counter;

    logic       clk = 1'b0;
    logic       rs = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       stall = 1'b0;
    logic [4:0] lim5 = '0;
    logic [7:0] lim8 = '0;

    logic [4:0] cnt5;
    logic [7:0] cnt8;
    logic       busy5, last5, done5;
    logic       busy8, last8, done8;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    multdiv_cycle_counter #(.WIDTH(5)) d5 (
        .clk(clk), .rs(rs), .start(start), .abort(abort),
        .stall(stall), .limit(lim5), .count(cnt5),
        .busy(busy5), .last(last5), .done(done5)
    );

    multdiv_cycle_counter #(.WIDTH(8)) d8 (
        .clk(clk), .rs(rs), .start(start), .abort(abort),
        .stall(stall), .limit(lim8), .count(cnt8),
        .busy(busy8), .last(last8), .done(done8)
    );

    // Model: running flag, done flag, step index, captured terminal step.
    int m_cnt[2];
    int m_lim[2];
    bit m_run[2];
    bit m_done[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_lim[i] = 0; m_run[i] = 0; m_done[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                m_run[i] <= 0; m_done[i] <= 0; m_cnt[i] <= 0; m_lim[i] <= 0;
            end else if (m_run[i]) begin
                if (abort) begin
                    m_run[i] <= 0; m_cnt[i] <= 0;
                end else if (!stall) begin
                    if (m_cnt[i] == m_lim[i]) begin
                        m_run[i] <= 0; m_done[i] <= 1;
                    end else begin
                        m_cnt[i] <= m_cnt[i] + 1;
                    end
                end
            end else begin
                m_done[i] <= 0;
                m_cnt[i] <= 0;
                if (!abort && start) begin
                    m_run[i] <= 1;
                    m_lim[i] <= (i == 0) ? int'(lim5) : int'(lim8);
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m5.count", 32'(cnt5), 32'(m_cnt[0]));
            chk("m5.busy", 32'(busy5), 32'(m_run[0]));
            chk("m5.last", 32'(last5), 32'(m_run[0] && m_cnt[0] == m_lim[0]));
            chk("m5.done", 32'(done5), 32'(m_done[0]));
            chk("m8.count", 32'(cnt8), 32'(m_cnt[1]));
            chk("m8.busy", 32'(busy8), 32'(m_run[1]));
            chk("m8.last", 32'(last8), 32'(m_run[1] && m_cnt[1] == m_lim[1]));
            chk("m8.done", 32'(done8), 32'(m_done[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until d5 done, returning edges taken; bound counts as a miss.
    task automatic wait_done5(input int bound, output int n);
        n = 0;
        while (!done5 && n < bound) begin
            step();
            n++;
        end
        if (!done5) chk("timeout5", 32'(n), 32'(bound + 1));
    endtask

    task automatic run_start5(input logic [4:0] l);
        lim5 = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int n;
        step();
        step();
        rs = 1'b0;
        cmp_en = 1'b1;
        chk("rst.count", 32'(cnt5), 0);
        chk("rst.busy", 32'(busy5), 0);
        chk("rst.done", 32'(done5), 0);
        chk("rst.last", 32'(last5), 0);
        step();

        // Nominal 32-step run.
        run_start5(5'd31);
        for (int k = 0; k < 32; k++) begin
            chk("nom.count", 32'(cnt5), 32'(k));
            chk("nom.last", 32'(last5), 32'(k == 31));
            chk("nom.busy", 32'(busy5), 1);
            step();
        end
        chk("nom.done", 32'(done5), 1);
        chk("nom.dcnt", 32'(cnt5), 31);
        chk("nom.dbusy", 32'(busy5), 0);
        step();
        chk("nom.post_done", 32'(done5), 0);
        chk("nom.post_cnt", 32'(cnt5), 0);
        chk("nom.post_busy", 32'(busy5), 0);

        // Reset mid-run.
        run_start5(5'd31);
        for (int k = 0; k < 10; k++) step();
        chk("rmid.at10", 32'(cnt5), 10);
        rs = 1'b1;
        step();
        rs = 1'b0;
        chk("rmid.count", 32'(cnt5), 0);
        chk("rmid.busy", 32'(busy5), 0);
        chk("rmid.done", 32'(done5), 0);
        step();
        chk("rmid.idle", 32'(busy5), 0);

        // Stall for two cycles at count 1, limit change mid-run.
        run_start5(5'd3);
        step();
        chk("stall.c1", 32'(cnt5), 1);
        stall = 1'b1;
        lim5 = 5'd0;
        step();
        chk("stall.h1", 32'(cnt5), 1);
        step();
        chk("stall.h2", 32'(cnt5), 1);
        stall = 1'b0;
        step();
        chk("stall.c2", 32'(cnt5), 2);
        wait_done5(10, n);
        chk("stall.lat", 32'(n + 5), 7);
        step();

        // Abort mid-run.
        run_start5(5'd5);
        step();
        step();
        chk("abort.c2", 32'(cnt5), 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort.count", 32'(cnt5), 0);
        chk("abort.busy", 32'(busy5), 0);
        for (int k = 0; k < 8; k++) begin
            chk("abort.nodone", 32'(done5), 0);
            step();
        end

        // Abort together with stall.
        run_start5(5'd5);
        step();
        abort = 1'b1;
        stall = 1'b1;
        step();
        abort = 1'b0;
        stall = 1'b0;
        chk("abst.busy", 32'(busy5), 0);
        chk("abst.count", 32'(cnt5), 0);
        step();
        chk("abst.done", 32'(done5), 0);

        // limit=0.
        run_start5(5'd0);
        chk("l0.busy", 32'(busy5), 1);
        chk("l0.last", 32'(last5), 1);
        chk("l0.count", 32'(cnt5), 0);
        step();
        chk("l0.done", 32'(done5), 1);
        step();
        chk("l0.after", 32'(done5), 0);

        // Back-to-back start from DONE.
        run_start5(5'd1);
        step();
        step();
        chk("b2b.done", 32'(done5), 1);
        run_start5(5'd2);
        chk("b2b.busy", 32'(busy5), 1);
        chk("b2b.count", 32'(cnt5), 0);
        chk("b2b.nodone", 32'(done5), 0);
        wait_done5(10, n);
        chk("b2b.lat", 32'(n), 3);
        step();

        // Start during RUN is ignored.
        run_start5(5'd4);
        step();
        lim5 = 5'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sir.count", 32'(cnt5), 2);
        wait_done5(10, n);
        chk("sir.lat", 32'(n + 3), 6);
        step();
        step();

        // WIDTH=8 full-range run.
        lim5 = 5'd0;
        lim8 = 8'd255;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!done8 && n < 400) begin
            if (last8) chk("w8.last", 32'(cnt8), 255);
            step();
            n++;
        end
        chk("w8.done", 32'(done8), 1);
        chk("w8.cnt", 32'(cnt8), 255);
        chk("w8.lat", 32'(n), 257);
        step();
        chk("w8.post", 32'(cnt8), 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multdiv_cycle_counter.md
# multdiv_cycle_counter

Parametrised cycle sequencer for the iterative multiply/divide unit. It replaces the fixed 5-bit free-running step counter. Software-visible behaviour: a start pulse arms a run with a programmable terminal count. The counter advances once per non-stalled cycle and emits a one-cycle done pulse at the terminal step. It also supports abort and stall. It sits between the multdiv control FSM and the shift/add datapath, and paces iterations for both 32-step multiply and divide.

## Interface
Parameters:
- WIDTH, 5, counter and limit width; maximum representable step is 2^WIDTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rs  in  1  reset; synchronous and active-high.
- start  in  1  pulse that begins a run; sampled in IDLE or DONE only.
- abort  in  1  cancels a run in progress; no done is produced.
- stall  in  1  holds count for this cycle while running.
- limit  in  WIDTH  terminal step index; captured on an accepted start.
- count  out  WIDTH  current step index, registered.
- busy  out  1  high while in RUN.
- last  out  1  high in RUN when count equals the captured limit.
- done  out  1  one-cycle pulse, high in the DONE state.

## Operation
- States:
  - IDLE: count=0.
  - RUN: count advances.
  - DONE: single cycle, done=1, count holds at limit.
- Priority each cycle: rs > abort > start > stall/advance.
- IDLE:
  - start=1 -> RUN; count<=0; limit_q<=limit.
  - Otherwise stay in IDLE.
- RUN:
  - abort=1 -> IDLE; count<=0; done stays 0.
  - stall=1 -> hold state and count.
  - count==limit_q -> DONE; count holds.
  - Otherwise count<=count+1.
  - start is ignored in RUN.
- DONE:
  - start=1 -> RUN with a fresh capture of limit; count<=0. Back-to-back runs need no idle gap.
  - abort=1 -> IDLE.
  - Otherwise -> IDLE; count<=0.
- limit=0: RUN lasts one non-stalled cycle, with count=0 and last=1, then DONE.
- Arithmetic: unsigned, WIDTH bits. count never exceeds limit_q, so it never wraps.
- stall is ignored in IDLE and DONE. stall and abort together in RUN: abort wins.
- A change on the limit input outside an accepted start has no effect on the current run.

## Timing
- Reset (rs=1 at an edge):
  - state=IDLE.
  - count=0, limit_q=0.
  - busy=0, last=0, done=0.
- Reset applies from any state, including mid-run. The next edge behaves as IDLE.
- count, state and limit_q are registered. busy, done and last decode from registers only, with no input-to-output combinational path.
- Latency with start at edge t and no stalls:
  - busy=1 from t+1.
  - count=k after edge t+1+k.
  - done high for the cycle after edge t+2+L, where L=limit.
- Each stalled RUN cycle delays every later event by exactly one cycle.
- Total start-to-done edges = L+2+(number of stalled RUN cycles).

## Structure
- Shared package multdiv_pkg holds:
  - the state enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - MULTDIV_STEPS_32 = 31, the terminal index for 32-step operations.
- Sub-module cycle_count_reg (parameter WIDTH) holds count:
  - Ports: clk, rs, clr, inc, q.
  - Synchronous clear with priority over increment.
- Top level holds the FSM, limit_q and the output decodes.

## Test plan
- Reset mid-run: limit=31, start; assert rs at count=10 -> next cycle count=0, busy=0, done=0, state IDLE.
- Nominal: WIDTH=5, limit=31, start at cycle 0 -> count 0..31 on cycles 1..32; last=1 only at count=31; done pulses one cycle at cycle 33; then count=0, busy=0.
- Stall and limit change: limit=3, stall high for 2 cycles at count=1 -> count stays 1 for 3 cycles total; done arrives at cycle 7. Changing limit to 0 mid-run does not alter this.
- Abort versus done: limit=5, abort at count=2 -> IDLE next cycle, count=0, done never asserted. Separately, abort and stall together -> abort wins.
- Edge cases:
  - limit=0: start -> one RUN cycle with count=0 and last=1, done on the next cycle.
  - start in DONE -> new run with count=0 and no IDLE cycle.
  - start during RUN -> ignored.
- WIDTH=8: limit=255 -> count reaches 255 without wrap; done at cycle 257.
